tblink_rpc_ep_mc: RTL and testbench



---
 rtl/tblink_rpc_ep_mc.sv | 234 +++++++++++++++++++++++
 tb/tb_tblink_rpc_ep_mc.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tblink_rpc_ep_mc.sv
// rtl/tblink_rpc_ep_mc.sv - multi-channel tblink RPC ring endpoint (optional round-robin: TBLINK_RPC_EP_MC_RR_EN)

// Byte FIFO; accepts nothing while reset is held so upstream sees ready low.
module tblink_rpc_ep_mc_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       uclock,
    input  logic       reset,
    input  logic [7:0] in_dat,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_dat,
    output logic       out_valid,
    input  logic       out_ready
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic        full, empty, push, pop;

    assign empty     = (wptr == rptr);
    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign in_ready  = !full && !reset;
    assign out_valid = !empty;
    assign out_dat   = mem[rptr[AW-1:0]];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage write.
    always_ff @(posedge uclock) begin
        if (push) mem[wptr[AW-1:0]] <= in_dat;
    end
endmodule

module tblink_rpc_ep_mc #(
    parameter int ADDR_BASE  = 1,
    parameter int N_TIP      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               uclock,
    input  logic               reset,
    input  logic               hreq_i,
    output logic               hreq_o,
    input  logic [N_TIP-1:0]   tip_hreq,
    input  logic [7:0]         neti_dat,
    input  logic               neti_valid,
    output logic               neti_ready,
    output logic [7:0]         neto_dat,
    output logic               neto_valid,
    input  logic               neto_ready,
    output logic [8*N_TIP-1:0] tipo_dat,
    output logic [N_TIP-1:0]   tipo_valid,
    input  logic [N_TIP-1:0]   tipo_ready,
    input  logic [8*N_TIP-1:0] tipi_dat,
    input  logic [N_TIP-1:0]   tipi_valid,
    output logic [N_TIP-1:0]   tipi_ready
);
    if (ADDR_BASE < 1 || ADDR_BASE + N_TIP - 1 > 127 || N_TIP < 1 || N_TIP > 8 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $fatal(1, "tblink_rpc_ep_mc: illegal ADDR_BASE/N_TIP/FIFO_DEPTH");
    end

    localparam int          NSRC   = N_TIP + 1;
    localparam logic [3:0]  RT_NET = 4'd8;
    localparam logic [7:0]  BASE8  = 8'(ADDR_BASE);
    localparam logic [7:0]  TOP8   = 8'(ADDR_BASE + N_TIP);

    typedef enum logic [1:0] {HDR, CNT, PAY} p_state_t;
    typedef enum logic [1:0] {O_IDLE, O_HDR, O_CNT, O_PAY} o_state_t;

    p_state_t   p_state, p_next;
    o_state_t   o_state, o_next;
    logic [3:0] rt, tgt, src, pick;
    logic [8:0] cnt, ocnt;
    logic [7:0] dest8;
    logic       owned, hdr_drop, tgt_ready, neti_hs, neto_hs, found;
    logic       pass_push, pass_in_ready;
    logic [N_TIP-1:0] tipo_push, tipo_in_ready;
    logic [N_TIP:0]   src_valid, src_pop;
    logic [7:0]       src_dat [NSRC];

    assign hreq_o = hreq_i | (|tip_hreq);
    assign dest8  = {1'b0, neti_dat[6:0]};
    assign owned  = (dest8 >= BASE8) && (dest8 < TOP8);

    tblink_rpc_ep_mc_fifo #(.DEPTH(FIFO_DEPTH)) u_pass (
        .uclock(uclock), .reset(reset),
        .in_dat(neti_dat), .in_valid(pass_push), .in_ready(pass_in_ready),
        .out_dat(src_dat[0]), .out_valid(src_valid[0]), .out_ready(src_pop[0])
    );

    for (genvar k = 0; k < N_TIP; k++) begin : g_tip
        tblink_rpc_ep_mc_fifo #(.DEPTH(FIFO_DEPTH)) u_tipo (
            .uclock(uclock), .reset(reset),
            .in_dat(neti_dat), .in_valid(tipo_push[k]), .in_ready(tipo_in_ready[k]),
            .out_dat(tipo_dat[8*k+:8]), .out_valid(tipo_valid[k]), .out_ready(tipo_ready[k])
        );
        tblink_rpc_ep_mc_fifo #(.DEPTH(FIFO_DEPTH)) u_tipi (
            .uclock(uclock), .reset(reset),
            .in_dat(tipi_dat[8*k+:8]), .in_valid(tipi_valid[k]), .in_ready(tipi_ready[k]),
            .out_dat(src_dat[k+1]), .out_valid(src_valid[k+1]), .out_ready(src_pop[k+1])
        );
    end

    // Input parser: route the current byte, drop owned headers, track payload count.
    always_comb begin
        p_next    = p_state;
        tgt       = rt;
        hdr_drop  = 1'b0;
        if (p_state == HDR) begin
            if (owned) begin
                tgt      = 4'(dest8 - BASE8);
                hdr_drop = 1'b1;
            end else begin
                tgt = RT_NET;
            end
        end
        tgt_ready = (tgt == RT_NET) ? pass_in_ready : 1'b0;
        for (int k = 0; k < N_TIP; k++)
            if (tgt == 4'(k)) tgt_ready = tipo_in_ready[k];
        neti_ready = hdr_drop ? !reset : tgt_ready;
        neti_hs    = neti_valid && neti_ready;
        pass_push  = neti_hs && !hdr_drop && (tgt == RT_NET);
        for (int k = 0; k < N_TIP; k++)
            tipo_push[k] = neti_hs && !hdr_drop && (tgt == 4'(k));
        case (p_state)
            HDR:     if (neti_hs) p_next = CNT;
            CNT:     if (neti_hs) p_next = PAY;
            PAY:     if (neti_hs && cnt == 9'd0) p_next = HDR;
            default: p_next = HDR;
        endcase
    end

    // Parser state register.
    always_ff @(posedge uclock or posedge reset) begin
        if (reset) p_state <= HDR;
        else       p_state <= p_next;
    end

    // Parser route and payload counter.
    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            rt  <= RT_NET;
            cnt <= '0;
        end else if (neti_hs) begin
            if (p_state == HDR) rt <= tgt;
            if (p_state == CNT) cnt <= {1'b0, neti_dat};
            if (p_state == PAY && cnt != 9'd0) cnt <= cnt - 1'b1;
        end
    end

`ifdef TBLINK_RPC_EP_MC_RR_EN
    logic [3:0] rr_ptr;

    // Round-robin search start; moves past each grant.
    always_ff @(posedge uclock or posedge reset) begin
        if (reset) rr_ptr <= '0;
        else if (o_state == O_IDLE && found) rr_ptr <= 4'((int'(pick) + 1) % NSRC);
    end
`endif

    // Out arbiter: pick a source in idle, then stream its whole packet to neto.
    always_comb begin
        o_next     = o_state;
        neto_valid = 1'b0;
        neto_dat   = 8'h00;
        src_pop    = '0;
        pick       = '0;
        found      = 1'b0;
`ifdef TBLINK_RPC_EP_MC_RR_EN
        for (int i = 0; i < NSRC; i++) begin
            int idx;
            idx = (int'(rr_ptr) + i) % NSRC;
            if (!found && src_valid[idx]) begin
                pick  = 4'(idx);
                found = 1'b1;
            end
        end
`else
        for (int i = 0; i < NSRC; i++) begin
            if (!found && src_valid[i]) begin
                pick  = 4'(i);
                found = 1'b1;
            end
        end
`endif
        for (int k = 0; k < NSRC; k++) begin
            if (src == 4'(k)) begin
                neto_valid = (o_state != O_IDLE) && src_valid[k];
                neto_dat   = (o_state != O_IDLE) ? src_dat[k] : 8'h00;
            end
        end
        neto_hs = neto_valid && neto_ready;
        for (int k = 0; k < NSRC; k++)
            src_pop[k] = neto_hs && (src == 4'(k));
        case (o_state)
            O_IDLE:  if (found) o_next = O_HDR;
            O_HDR:   if (neto_hs) o_next = O_CNT;
            O_CNT:   if (neto_hs) o_next = O_PAY;
            O_PAY:   if (neto_hs && ocnt == 9'd0) o_next = O_IDLE;
            default: o_next = O_IDLE;
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge uclock or posedge reset) begin
        if (reset) o_state <= O_IDLE;
        else       o_state <= o_next;
    end

    // Granted source and outgoing payload counter.
    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            src  <= '0;
            ocnt <= '0;
        end else begin
            if (o_state == O_IDLE && found) src <= pick;
            if (o_state == O_CNT && neto_hs) ocnt <= {1'b0, neto_dat};
            if (o_state == O_PAY && neto_hs && ocnt != 9'd0) ocnt <= ocnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_tblink_rpc_ep_mc.sv
// tb/tb_tblink_rpc_ep_mc.sv - directed self-checking bench for tblink_rpc_ep_mc
module tb_tblink_rpc_ep_mc;
    logic        uclock = 1'b0;
    logic        reset  = 1'b1;
    logic        hreq_i = 1'b0;
    logic        hreq_o;
    logic [1:0]  tip_hreq = 2'b00;
    logic [7:0]  neti_dat = 8'h00;
    logic        neti_valid = 1'b0;
    logic        neti_ready;
    logic [7:0]  neto_dat;
    logic        neto_valid;
    logic        neto_ready = 1'b1;
    logic [15:0] tipo_dat;
    logic [1:0]  tipo_valid;
    logic [1:0]  tipo_ready = 2'b11;
    logic [15:0] tipi_dat = 16'h0000;
    logic [1:0]  tipi_valid = 2'b00;
    logic [1:0]  tipi_ready;

    int checks = 0;
    int passes = 0;
    int tmo    = 0;
    logic [7:0] neto_q[$];
    logic [7:0] tipo0_q[$];
    logic [7:0] tipo1_q[$];

    tblink_rpc_ep_mc #(.ADDR_BASE(1), .N_TIP(2), .FIFO_DEPTH(4)) dut (
        .uclock(uclock), .reset(reset), .hreq_i(hreq_i), .hreq_o(hreq_o), .tip_hreq(tip_hreq),
        .neti_dat(neti_dat), .neti_valid(neti_valid), .neti_ready(neti_ready),
        .neto_dat(neto_dat), .neto_valid(neto_valid), .neto_ready(neto_ready),
        .tipo_dat(tipo_dat), .tipo_valid(tipo_valid), .tipo_ready(tipo_ready),
        .tipi_dat(tipi_dat), .tipi_valid(tipi_valid), .tipi_ready(tipi_ready)
    );

    always #5 uclock = ~uclock;

    always @(negedge uclock) begin
        if (neto_valid && neto_ready) neto_q.push_back(neto_dat);
        if (tipo_valid[0] && tipo_ready[0]) tipo0_q.push_back(tipo_dat[7:0]);
        if (tipo_valid[1] && tipo_ready[1]) tipo1_q.push_back(tipo_dat[15:8]);
    end

    task automatic clear_qs();
        neto_q.delete();
        tipo0_q.delete();
        tipo1_q.delete();
        tmo = 0;
    endtask

    task automatic net_send(input logic [7:0] b);
        int n = 0;
        neti_dat   = b;
        neti_valid = 1'b1;
        @(negedge uclock);
        while (!neti_ready && n < 300) begin
            @(negedge uclock);
            n++;
        end
        if (!neti_ready) tmo++;
        @(posedge uclock); #1;
        neti_valid = 1'b0;
    endtask

    task automatic tipi_send(input int ch, input logic [7:0] b);
        int n = 0;
        tipi_dat[8*ch+:8] = b;
        tipi_valid[ch]    = 1'b1;
        @(negedge uclock);
        while (!tipi_ready[ch] && n < 300) begin
            @(negedge uclock);
            n++;
        end
        if (!tipi_ready[ch]) tmo++;
        @(posedge uclock); #1;
        tipi_valid[ch] = 1'b0;
    endtask

    task automatic wait_neto(input int n);
        int c = 0;
        while (neto_q.size() < n && c < 2000) begin
            @(negedge uclock);
            c++;
        end
        if (neto_q.size() < n) tmo++;
        @(posedge uclock); #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge uclock);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (neti_ready !== 1'b0) $display("FAIL rst_neti_ready got %b want 0", neti_ready); else passes++;
        checks++; if (tipi_ready !== 2'b00) $display("FAIL rst_tipi_ready got %b want 00", tipi_ready); else passes++;
        checks++; if (neto_valid !== 1'b0) $display("FAIL rst_neto_valid got %b want 0", neto_valid); else passes++;
        checks++; if (tipo_valid !== 2'b00) $display("FAIL rst_tipo_valid got %b want 00", tipo_valid); else passes++;
        @(posedge uclock); #1;
        reset = 1'b0;
        wait_cycles(1);
        checks++; if (neti_ready !== 1'b1) $display("FAIL post_rst_neti_ready got %b want 1", neti_ready); else passes++;
    endtask

    task automatic test_local();
        logic [7:0] exp[$];
        logic [7:0] got;
        clear_qs();
        exp = '{8'h03, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
        net_send(8'h02); net_send(8'h03);
        net_send(8'hA0); net_send(8'hA1); net_send(8'hA2); net_send(8'hA3);
        wait_cycles(6);
        for (int i = 0; i < 5; i++) begin
            got = (i < tipo1_q.size()) ? tipo1_q[i] : 8'hxx;
            checks++; if (got !== exp[i]) $display("FAIL local_ch1_byte%0d got %h want %h", i, got, exp[i]); else passes++;
        end
        checks++; if (tipo1_q.size() !== 5) $display("FAIL local_ch1_len got %0d want 5", tipo1_q.size()); else passes++;
        checks++; if (tipo0_q.size() !== 0) $display("FAIL local_ch0_idle got %0d want 0", tipo0_q.size()); else passes++;
        checks++; if (neto_q.size() !== 0) $display("FAIL local_neto_idle got %0d want 0", neto_q.size()); else passes++;
        checks++; if (tmo !== 0) $display("FAIL local_timeout got %0d want 0", tmo); else passes++;
    endtask

    task automatic test_pass();
        logic [7:0] exp[$];
        logic [7:0] got;
        clear_qs();
        exp = '{8'h85, 8'h00, 8'h55};
        net_send(8'h85); net_send(8'h00); net_send(8'h55);
        wait_neto(3);
        wait_cycles(3);
        for (int i = 0; i < 3; i++) begin
            got = (i < neto_q.size()) ? neto_q[i] : 8'hxx;
            checks++; if (got !== exp[i]) $display("FAIL pass_byte%0d got %h want %h", i, got, exp[i]); else passes++;
        end
        checks++; if (neto_q.size() !== 3) $display("FAIL pass_len got %0d want 3", neto_q.size()); else passes++;
        checks++; if (tipo0_q.size() + tipo1_q.size() !== 0) $display("FAIL pass_tipo_idle got %0d want 0", tipo0_q.size() + tipo1_q.size()); else passes++;
        checks++; if (tmo !== 0) $display("FAIL pass_timeout got %0d want 0", tmo); else passes++;
    endtask

    task automatic test_backpressure();
        logic [7:0] exp[$];
        logic [7:0] got;
        clear_qs();
        exp = '{8'h7F, 8'h07, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hD6, 8'hD7};
        neto_ready = 1'b0;
        for (int i = 0; i < 4; i++) net_send(exp[i]);
        neti_dat   = exp[4];
        neti_valid = 1'b1;
        repeat (3) @(negedge uclock);
        checks++; if (neti_ready !== 1'b0) $display("FAIL bp_stall got %b want 0", neti_ready); else passes++;
        checks++; if (neto_valid !== 1'b1 || neto_dat !== 8'h7F) $display("FAIL bp_head got %b/%h want 1/7f", neto_valid, neto_dat); else passes++;
        @(posedge uclock); #1;
        neto_ready = 1'b1;
        for (int i = 4; i < 10; i++) net_send(exp[i]);
        wait_neto(10);
        wait_cycles(3);
        for (int i = 0; i < 10; i++) begin
            got = (i < neto_q.size()) ? neto_q[i] : 8'hxx;
            checks++; if (got !== exp[i]) $display("FAIL bp_byte%0d got %h want %h", i, got, exp[i]); else passes++;
        end
        checks++; if (neto_q.size() !== 10) $display("FAIL bp_len got %0d want 10", neto_q.size()); else passes++;
        checks++; if (tmo !== 0) $display("FAIL bp_timeout got %0d want 0", tmo); else passes++;
    endtask

    task automatic test_arbitration();
        logic [7:0] exp[$];
        logic [7:0] got;
        clear_qs();
`ifdef TBLINK_RPC_EP_MC_RR_EN
        exp = '{8'h86, 8'h00, 8'hC0, 8'h90, 8'h00, 8'hB0, 8'h91, 8'h00, 8'hB1, 8'h87, 8'h00, 8'hC1};
`else
        exp = '{8'h86, 8'h00, 8'hC0, 8'h87, 8'h00, 8'hC1, 8'h90, 8'h00, 8'hB0, 8'h91, 8'h00, 8'hB1};
`endif
        neto_ready = 1'b0;
        net_send(8'h86); net_send(8'h00); net_send(8'hC0);
        tipi_send(0, 8'h90); tipi_send(0, 8'h00); tipi_send(0, 8'hB0);
        tipi_send(1, 8'h91); tipi_send(1, 8'h00); tipi_send(1, 8'hB1);
        neto_ready = 1'b1;
        net_send(8'h87); net_send(8'h00); net_send(8'hC1);
        wait_neto(12);
        wait_cycles(3);
        for (int i = 0; i < 12; i++) begin
            got = (i < neto_q.size()) ? neto_q[i] : 8'hxx;
            checks++; if (got !== exp[i]) $display("FAIL arb_byte%0d got %h want %h", i, got, exp[i]); else passes++;
        end
        checks++; if (neto_q.size() !== 12) $display("FAIL arb_len got %0d want 12", neto_q.size()); else passes++;
        checks++; if (tmo !== 0) $display("FAIL arb_timeout got %0d want 0", tmo); else passes++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        clear_qs();
        tipo_ready = 2'b00;
        neto_ready = 1'b0;
        net_send(8'h01); net_send(8'h03);
        tipi_send(0, 8'h90);
        wait_cycles(3);
        checks++; if (neto_valid !== 1'b1 || tipo_valid[0] !== 1'b1) $display("FAIL mid_pre got %b/%b want 1/1", neto_valid, tipo_valid[0]); else passes++;
        reset = 1'b1;
        #1;
        checks++; if (neto_valid !== 1'b0) $display("FAIL mid_neto_valid got %b want 0", neto_valid); else passes++;
        checks++; if (tipo_valid !== 2'b00) $display("FAIL mid_tipo_valid got %b want 00", tipo_valid); else passes++;
        checks++; if (neti_ready !== 1'b0 || tipi_ready !== 2'b00) $display("FAIL mid_readys got %b/%b want 0/00", neti_ready, tipi_ready); else passes++;
        @(posedge uclock); #1;
        reset      = 1'b0;
        tipo_ready = 2'b11;
        neto_ready = 1'b1;
        wait_cycles(1);
        clear_qs();
        net_send(8'h01); net_send(8'h00); net_send(8'h11);
        wait_cycles(6);
        got = (tipo0_q.size() > 0) ? tipo0_q[0] : 8'hxx;
        checks++; if (got !== 8'h00) $display("FAIL mid_ch0_cnt got %h want 00", got); else passes++;
        got = (tipo0_q.size() > 1) ? tipo0_q[1] : 8'hxx;
        checks++; if (got !== 8'h11) $display("FAIL mid_ch0_pay got %h want 11", got); else passes++;
        checks++; if (tipo0_q.size() !== 2) $display("FAIL mid_ch0_len got %0d want 2", tipo0_q.size()); else passes++;
        checks++; if (neto_q.size() + tipo1_q.size() !== 0) $display("FAIL mid_others got %0d want 0", neto_q.size() + tipo1_q.size()); else passes++;
        checks++; if (tmo !== 0) $display("FAIL mid_timeout got %0d want 0", tmo); else passes++;
    endtask

    task automatic test_max_halt();
        int bad = 0;
        logic [7:0] want;
        clear_qs();
        net_send(8'h85);
        net_send(8'hFF);
        for (int i = 0; i < 256; i++) net_send(8'(i ^ 8'h5A));
        wait_neto(258);
        wait_cycles(4);
        checks++; if (neto_q.size() !== 258) $display("FAIL max_len got %0d want 258", neto_q.size()); else passes++;
        for (int i = 0; i < 258 && i < neto_q.size(); i++) begin
            want = (i == 0) ? 8'h85 : (i == 1) ? 8'hFF : 8'((i - 2) ^ 8'h5A);
            if (neto_q[i] !== want) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL max_bytes got %0d bad want 0", bad); else passes++;
        checks++; if (neto_valid !== 1'b0) $display("FAIL max_idle got %b want 0", neto_valid); else passes++;
        checks++; if (tmo !== 0) $display("FAIL max_timeout got %0d want 0", tmo); else passes++;
        checks++; if (hreq_o !== 1'b0) $display("FAIL halt_none got %b want 0", hreq_o); else passes++;
        tip_hreq = 2'b10;
        #1;
        checks++; if (hreq_o !== 1'b1) $display("FAIL halt_tip got %b want 1", hreq_o); else passes++;
        tip_hreq = 2'b00;
        hreq_i   = 1'b1;
        #1;
        checks++; if (hreq_o !== 1'b1) $display("FAIL halt_up got %b want 1", hreq_o); else passes++;
        hreq_i = 1'b0;
        #1;
        checks++; if (hreq_o !== 1'b0) $display("FAIL halt_clear got %b want 0", hreq_o); else passes++;
    endtask

    initial begin
        test_reset();
        test_local();
        test_pass();
        test_backpressure();
        test_arbitration();
        test_reset_mid();
        test_max_halt();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
